instruction_fetch_unit: RTL



---
 rtl/instruction_fetch_unit.sv | 116 +++++++++++
 1 files changed

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch front-end: holds the PC, waits out the memory read delay,
// captures the word and hands it to decode over a valid/ready handshake.
//
// state   | meaning
// --------+---------------------------------------------------------------
// S_WAIT  | Address stable; counting cycles until Data can be sampled
// S_HOLD  | instr valid; waiting for decode to accept it
// S_FAULT | misaligned redirect target seen; frozen until reset
module instruction_fetch_unit #(
  parameter int RD_WAIT = 2,
  parameter int CNT_W   = 8
) (
  input  logic        CLK,
  input  logic        Reset_L,
  input  logic [63:0] startPC,
  output logic [63:0] Address,
  input  logic [31:0] Data,
  output logic [31:0] instr,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [63:0] pc_out,
  input  logic        redirect,
  input  logic [63:0] redirect_target,
  output logic        fault,
  output logic [31:0] fetch_count
);

  typedef enum logic [1:0] {S_WAIT, S_HOLD, S_FAULT} state_t;

  localparam logic [CNT_W-1:0] RD_WAIT_C = CNT_W'(RD_WAIT);

  state_t            state_q, state_d;
  logic [63:0]       pc_q, pc_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [31:0]       instr_q, instr_d;
  logic              valid_q, valid_d;
  logic              fault_q, fault_d;
  logic [31:0]       fetch_count_q, fetch_count_d;

  logic misaligned;
  assign misaligned = (redirect_target[1:0] != 2'b00);

  always_ff @(posedge CLK) begin
    if (!Reset_L) begin
      state_q       <= S_WAIT;
      pc_q          <= startPC;
      cnt_q         <= '0;
      instr_q       <= '0;
      valid_q       <= 1'b0;
      fault_q       <= 1'b0;
      fetch_count_q <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      cnt_q         <= cnt_d;
      instr_q       <= instr_d;
      valid_q       <= valid_d;
      fault_q       <= fault_d;
      fetch_count_q <= fetch_count_d;
    end
  end

  // Redirect outranks both capture (WAIT) and accept (HOLD).
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_WAIT: begin
        if (redirect)                state_d = misaligned ? S_FAULT : S_WAIT;
        else if (cnt_q == RD_WAIT_C) state_d = S_HOLD;
      end
      S_HOLD: begin
        if (redirect)         state_d = misaligned ? S_FAULT : S_WAIT;
        else if (instr_ready) state_d = S_WAIT;
      end
      S_FAULT: state_d = S_FAULT;
      default: state_d = S_FAULT;
    endcase
  end

  always_comb begin
    pc_d          = pc_q;
    cnt_d         = cnt_q;
    instr_d       = instr_q;
    valid_d       = valid_q;
    fault_d       = fault_q;
    fetch_count_d = fetch_count_q;
    if (state_q == S_WAIT || state_q == S_HOLD) begin
      if (redirect) begin
        pc_d    = redirect_target;
        cnt_d   = '0;
        valid_d = 1'b0;
        if (misaligned) fault_d = 1'b1;
      end else if (state_q == S_WAIT) begin
        if (cnt_q == RD_WAIT_C) begin
          instr_d = Data;
          valid_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end else if (instr_ready) begin
        pc_d    = pc_q + 64'd4;
        cnt_d   = '0;
        valid_d = 1'b0;
        if (fetch_count_q != 32'hFFFF_FFFF) fetch_count_d = fetch_count_q + 32'd1;
      end
    end
  end

  assign Address     = pc_q;
  assign pc_out      = pc_q;
  assign instr       = instr_q;
  assign instr_valid = valid_q;
  assign fault       = fault_q;
  assign fetch_count = fetch_count_q;

endmodule
